// File: rtl/pwm_pkg.sv
// Shared constants and state type for the PWM shadow-register update sequencer.
package pwm_pkg;

  localparam int unsigned PWM_NUM_CH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StInit   = ST_INIT,
    StRun    = ST_RUN,
    StCommit = ST_COMMIT
  } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_ctrl_if.sv
// CCR write handshake between the register file (master) and the update sequencer (slave).
interface pwm_shadow_ctrl_if #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned CNT_WIDTH = 16
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic                 wr_valid;
  logic                 wr_ready;
  logic [CH_W-1:0]      wr_ch;
  logic [CNT_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_ch, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_data, output wr_ready);

endinterface

// File: rtl/pwm_prio_enc.sv
// Combinational lowest-set-bit finder used to order commit-sweep writes.
module pwm_prio_enc #(
  parameter int unsigned  NUM_CH = 16,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  output logic [CH_W-1:0]   idx_o,
  output logic              any_o
);

  // Scan high to low so the lowest set bit is the last one assigned.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = CH_W'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/pwm_shadow_ctrl.sv
// PWM compare update sequencer: pending CCR bank, start-up preload sweep, overflow-aligned commit.
// Optional macro PWM_UPDATE_IRQ_EN adds upd_done_o, a pulse after each sweep's final write.
module pwm_shadow_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned  NUM_CH    = PWM_NUM_CH,
  parameter int unsigned  CNT_WIDTH = 16,
  localparam int unsigned CH_W      = $clog2(NUM_CH)
) (
  input  logic                 clk_psc_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 overflow_i,
  pwm_shadow_ctrl_if.slave     wr_if,
  output logic                 cnt_en_o,
  output logic                 shd_we_o,
  output logic [CH_W-1:0]      shd_ch_o,
  output logic [CNT_WIDTH-1:0] shd_data_o,
  output logic                 busy_o,
  output logic                 overrun_o,
  input  logic                 clr_overrun_i
`ifdef PWM_UPDATE_IRQ_EN
  ,
  output logic                 upd_done_o
`endif
);

  pwm_state_e           state_q, state_d;
  logic [CH_W-1:0]      idx_q, idx_d;
  logic [NUM_CH-1:0]    dirty_q, dirty_d;
  logic [NUM_CH-1:0]    mask_q, mask_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 overrun_q, overrun_d;
  logic [CNT_WIDTH-1:0] pend_q [NUM_CH];

  logic              wr_fire, wr_ok;
  logic [NUM_CH-1:0] wr_bit, dirty_set;
  logic [CH_W-1:0]   enc_idx, shd_ch;
  logic              enc_any, last_init, commit_last;

  pwm_prio_enc #(
    .NUM_CH (NUM_CH)
  ) u_prio_enc (
    .mask_i (mask_q),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  // Out-of-range channels only exist when NUM_CH is not a power of two.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_full
    assign wr_ok = 1'b1;
  end else begin : g_ch_part
    assign wr_ok = (32'(wr_if.wr_ch) < NUM_CH);
  end

  assign wr_fire     = wr_if.wr_valid && wr_if.wr_ready;
  assign wr_bit      = (wr_fire && wr_ok) ? (NUM_CH'(1) << wr_if.wr_ch) : '0;
  assign dirty_set   = dirty_q | wr_bit;
  assign last_init   = (idx_q == CH_W'(NUM_CH - 1));
  assign commit_last = ((mask_q & (mask_q - NUM_CH'(1))) == '0);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dirty_d     = dirty_set;
    mask_d      = mask_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      StIdle: begin
        if (start_i && !stop_i) begin
          state_d = StInit;
          idx_d   = '0;
        end
      end
      StInit: begin
        dirty_d[idx_q] = 1'b0;
        idx_d          = idx_q + CH_W'(1);
        if (stop_i)         state_d = StIdle;
        else if (last_init) state_d = StRun;
      end
      StRun: begin
        // A write landing with the overflow joins this commit rather than the next one.
        if (overflow_i && (dirty_set != '0)) begin
          mask_d      = dirty_set;
          dirty_d     = '0;
          stop_pend_d = stop_i;
          state_d     = StCommit;
        end else if (stop_i) begin
          state_d = StIdle;
        end
      end
      StCommit: begin
        mask_d[enc_idx] = 1'b0;
        if (stop_i) stop_pend_d = 1'b1;
        if (commit_last) begin
          state_d     = (stop_pend_q || stop_i) ? StIdle : StRun;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (state_q == StCommit && overflow_i) overrun_d = 1'b1;
    else if (clr_overrun_i)                overrun_d = 1'b0;
  end

  always_ff @(posedge clk_psc_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      dirty_q     <= '0;
      mask_q      <= '0;
      stop_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dirty_q     <= dirty_d;
      mask_q      <= mask_d;
      stop_pend_q <= stop_pend_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk_psc_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) pend_q[i] <= '0;
    end else if (wr_fire && wr_ok) begin
      pend_q[wr_if.wr_ch] <= wr_if.wr_data;
    end
  end

  // All outputs decode flops only; COMMIT always holds a non-empty mask.
  assign cnt_en_o       = (state_q == StRun) || (state_q == StCommit);
  assign busy_o         = (state_q == StInit) || (state_q == StCommit);
  assign wr_if.wr_ready = (state_q == StIdle) || (state_q == StRun);
  assign shd_we_o       = busy_o && ((state_q == StInit) || enc_any);
  assign shd_ch         = !shd_we_o ? '0 : ((state_q == StInit) ? idx_q : enc_idx);
  assign shd_ch_o       = shd_ch;
  assign shd_data_o     = shd_we_o ? pend_q[shd_ch] : '0;
  assign overrun_o      = overrun_q;

`ifdef PWM_UPDATE_IRQ_EN
  logic upd_done_q;

  always_ff @(posedge clk_psc_i or posedge rst_i) begin
    if (rst_i) upd_done_q <= 1'b0;
    else       upd_done_q <= ((state_q == StInit) && last_init) ||
                             ((state_q == StCommit) && commit_last);
  end

  assign upd_done_o = upd_done_q;
`endif

endmodule

// File: doc/pwm_shadow_ctrl.md
Name: pwm_shadow_ctrl

Overview:
- Update sequencer between the I2C register file and the PWM core.
- Buffers per-channel compare (CCR) writes in a pending bank.
- Commits dirty entries to the compare shadow bank over one write port, only at counter overflow, so each PWM period sees a consistent set of duties.
- Owns the counter enable, including the start-up preload sweep and the stop sequencing.

Parameters:
- NUM_CH, 16, number of PWM channels.
- CNT_WIDTH, 16, compare value width; must match the counter width.
- CH_W, $clog2(NUM_CH), channel index width; localparam, not overridable.

Ports:
- clk_psc_i  input  1  prescaler-domain clock, same clock as the counter.
- rst_i  input  1  asynchronous reset, active-high.
- start_i  input  1  one-cycle start request.
- stop_i  input  1  one-cycle stop request.
- overflow_i  input  1  counter overflow pulse.
- wr_valid_i  input  1  CCR write request.
- wr_ready_o  output  1  CCR write accepted when wr_valid_i and wr_ready_o are both high.
- wr_ch_i  input  CH_W  target channel of the CCR write.
- wr_data_i  input  CNT_WIDTH  new compare value.
- cnt_en_o  output  1  counter enable.
- shd_we_o  output  1  shadow bank write strobe.
- shd_ch_o  output  CH_W  shadow bank write channel.
- shd_data_o  output  CNT_WIDTH  shadow bank write data.
- busy_o  output  1  high in INIT or COMMIT.
- overrun_o  output  1  sticky: an overflow arrived during COMMIT.
- clr_overrun_i  input  1  clears overrun_o.

Behaviour:
- Reset values: all outputs 0 except wr_ready_o = 1. Pending bank = 0, dirty vector = 0, state = IDLE.
- Pending bank: NUM_CH x CNT_WIDTH registers.
  - An accepted write stores wr_data_i into pending[wr_ch_i] and sets dirty[wr_ch_i].
  - A wr_ch_i value >= NUM_CH is accepted and ignored.
- wr_ready_o = 1 in IDLE and RUN, 0 in INIT and COMMIT (backpressure).
- State machine IDLE/INIT/RUN/COMMIT, registered outputs:
  - IDLE: cnt_en_o = 0.
    - start_i -> INIT with sweep index 0.
    - stop_i is ignored.
    - If start_i and stop_i are high in the same cycle, stop wins and the block stays in IDLE.
  - INIT: writes every channel 0..NUM_CH-1 in ascending order, one per cycle, regardless of dirty.
    - Each cycle: shd_we_o = 1, shd_ch_o = index, shd_data_o = pending[index]; the dirty bit for that index is cleared.
    - After the last channel -> RUN. cnt_en_o rises on the cycle after the last shd_we_o.
    - Latency from start_i to cnt_en_o is NUM_CH+1 cycles.
    - stop_i in INIT aborts to IDLE next cycle. Unswept dirty bits are kept.
  - RUN: cnt_en_o = 1.
    - overflow_i with dirty != 0: snapshot dirty into commit_mask, clear dirty, -> COMMIT.
    - overflow_i with dirty == 0: stay in RUN.
    - stop_i -> IDLE; cnt_en_o falls on the next cycle.
    - If stop_i and overflow_i coincide, the commit runs first and the stop is latched.
  - COMMIT: cnt_en_o stays 1.
    - Each cycle, write the lowest set bit k of commit_mask: shd_we_o = 1, shd_ch_o = k, shd_data_o = pending[k]; clear the bit.
    - Duration equals popcount(commit_mask) cycles.
    - When the mask empties -> RUN, or -> IDLE if a stop was latched during COMMIT.
    - First shadow write occurs the cycle after overflow_i.
    - overflow_i during COMMIT sets overrun_o; the sweep continues unchanged.
- overrun_o is cleared by clr_overrun_i. If set and clear coincide, set wins.
- shd_we_o is never high outside INIT and COMMIT.
- busy_o = (state == INIT) || (state == COMMIT).
- rst_i mid-sweep returns to IDLE immediately; pending contents are lost.

Optional Feature:
- Macro: PWM_UPDATE_IRQ_EN.
- Defined: adds output port upd_done_o (1 bit, reset 0).
  - Pulses high for one cycle on the cycle after the final shadow write of each INIT or COMMIT sweep.
- Not defined: port absent, no extra logic.

Decomposition:
- Package pwm_pkg holds:
  - PWM_NUM_CH default (16).
  - State encoding constants ST_IDLE = 2'd0, ST_INIT = 2'd1, ST_RUN = 2'd2, ST_COMMIT = 2'd3.
- Sub-module pwm_prio_enc: combinational lowest-set-bit finder.
  - Parameter NUM_CH.
  - Inputs: NUM_CH-bit mask.
  - Outputs: CH_W-bit index, any_o.
  - Used by COMMIT.

Test Plan:
- Reset, then start_i with pending all 0 -> 16 shadow writes ch0..ch15, data 0; cnt_en_o = 1 on cycle 17; wr_ready_o low during the sweep.
- In RUN, write ch3 = 0x0100 and ch9 = 0x0200, then pulse overflow_i -> two writes in consecutive cycles (ch3/0x0100, then ch9/0x0200) starting the cycle after the pulse; dirty cleared; back to RUN.
- In RUN, overflow_i with no pending writes -> no shd_we_o, state stays RUN.
- Dirty all 16 channels, overflow_i, then a second overflow_i 5 cycles later -> overrun_o = 1 and all 16 writes complete; clr_overrun_i -> overrun_o = 0.
- stop_i coincident with overflow_i while ch5 is dirty -> ch5 committed, then IDLE, cnt_en_o = 0.
- start_i and stop_i together in IDLE -> remains IDLE, no shadow writes.
